l2_instr_cache_responder: RTL and testbench

//  Second-level instruction cache that answers L1 instruction-cache misses. On an L1

---
 rtl/l2_cache_pkg.sv | 28 ++
 rtl/l2_way_select.sv | 17 +
 rtl/l2_instr_cache_responder.sv | 155 +++++++++++++++
 tb/tb_l2_instr_cache_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the L2 instruction cache.
package l2_cache_pkg;

  localparam int unsigned L2_ADDR_WIDTH = 32;
  localparam int unsigned L2_DATA_WIDTH = 32;
  localparam int unsigned L2_NUM_SETS   = 512;

  function automatic int unsigned l2_idx_width(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Lines are one word, so the two byte-offset bits sit below the index.
  function automatic int unsigned l2_tag_width(input int unsigned addr_width,
                                               input int unsigned num_sets);
    return addr_width - 2 - $clog2(num_sets);
  endfunction

  localparam int unsigned L2_IDX_W = l2_idx_width(L2_NUM_SETS);
  localparam int unsigned L2_TAG_W = l2_tag_width(L2_ADDR_WIDTH, L2_NUM_SETS);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM,
    RESPOND
  } l2_state_e;

endpackage

// File: rtl/l2_way_select.sv
// Victim choice for a 2-way set: first invalid way (way0 first), else the LRU way.
module l2_way_select (
  input  logic [1:0] valid,
  input  logic       lru,
  output logic       victim
);

  always_comb begin
    victim = lru;
    if (!valid[0]) begin
      victim = 1'b0;
    end else if (!valid[1]) begin
      victim = 1'b1;
    end
  end

endmodule

// File: rtl/l2_instr_cache_responder.sv
// 2-way set-associative L2 instruction cache serving L1 fill requests.
// Optional L2_PERF_COUNTERS_EN adds saturating hit/miss counter outputs.
module l2_instr_cache_responder
  import l2_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = L2_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
  parameter int unsigned NUM_SETS   = L2_NUM_SETS,
  parameter int unsigned NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l1_req_i,
  input  logic [ADDR_WIDTH-1:0] l1_addr_i,
  output logic                  l2_cache_valid_o,
  output logic [DATA_WIDTH-1:0] l2_cache_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
`ifdef L2_PERF_COUNTERS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);

  localparam int unsigned IDX   = l2_idx_width(NUM_SETS);
  localparam int unsigned TAG_W = l2_tag_width(ADDR_WIDTH, NUM_SETS);

  if (NUM_WAYS != 2) begin : g_bad_ways
    $error("l2_instr_cache_responder supports NUM_WAYS == 2 only");
  end
  if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_sets
    $error("l2_instr_cache_responder needs NUM_SETS a power of two >= 2");
  end

  l2_state_e state_q, state_d;

  logic [ADDR_WIDTH-3:0] req_addr_q;
  logic [IDX-1:0]        set_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [NUM_SETS-1:0]   valid_q [2];
  logic [NUM_SETS-1:0]   lru_q;
  logic [TAG_W-1:0]      tag_mem  [2][NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [2][NUM_SETS];
  logic                  victim_q, victim;
  logic                  hit0, hit1, hit, fill_en;
  logic [1:0]            way_valid;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^l1_addr_i[1:0];

  always_comb begin
    set_idx   = req_addr_q[IDX-1:0];
    req_tag   = req_addr_q[ADDR_WIDTH-3:IDX];
    way_valid = {valid_q[1][set_idx], valid_q[0][set_idx]};
    hit0      = way_valid[0] && (tag_mem[0][set_idx] == req_tag);
    hit1      = way_valid[1] && (tag_mem[1][set_idx] == req_tag);
    hit       = hit0 || hit1;
    fill_en   = (state_q == MEM) && mem_valid_i;
  end

  l2_way_select u_way_select (
    .valid  (way_valid),
    .lru    (lru_q[set_idx]),
    .victim (victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The strobe is qualified live so an L1 that redirected while we were busy is not filled.
  always_comb begin
    state_d          = state_q;
    l2_cache_valid_o = 1'b0;
    case (state_q)
      IDLE:    if (l1_req_i) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? RESPOND : MEM;
      MEM:     if (mem_valid_i) state_d = RESPOND;
      RESPOND: begin
        l2_cache_valid_o = l1_req_i && (l1_addr_i[ADDR_WIDTH-1:2] == req_addr_q);
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_req_o is released at the end of RESPOND, one cycle after the data beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q      <= '0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
      l2_cache_data_o <= '0;
      valid_q[0]      <= '0;
      valid_q[1]      <= '0;
      lru_q           <= '0;
      victim_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (l1_req_i) req_addr_q <= l1_addr_i[ADDR_WIDTH-1:2];
        end
        LOOKUP: begin
          if (hit) begin
            l2_cache_data_o <= hit1 ? data_mem[1][set_idx] : data_mem[0][set_idx];
            lru_q[set_idx]  <= ~hit1;
          end else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {req_addr_q, 2'b00};
            victim_q   <= victim;
          end
        end
        MEM: begin
          if (mem_valid_i) begin
            valid_q[victim_q][set_idx] <= 1'b1;
            lru_q[set_idx]             <= ~victim_q;
            l2_cache_data_o            <= mem_data_i;
          end
        end
        RESPOND: mem_req_o <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[victim_q][set_idx]  <= req_tag;
      data_mem[victim_q][set_idx] <= mem_data_i;
    end
  end

`ifdef L2_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
      end else begin
        if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_instr_cache_responder.sv
// Directed table-driven bench for l2_instr_cache_responder with a simple memory responder.
module tb_l2_instr_cache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        l1_req;
  logic [31:0] l1_addr;
  logic        l2_valid;
  logic [31:0] l2_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
`ifdef L2_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_instr_cache_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_SETS   (512),
    .NUM_WAYS   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .l1_req_i         (l1_req),
    .l1_addr_i        (l1_addr),
    .l2_cache_valid_o (l2_valid),
    .l2_cache_data_o  (l2_data),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_valid_i      (mem_valid),
    .mem_data_i       (mem_data)
`ifdef L2_PERF_COUNTERS_EN
    ,
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          lat;        // memory cycles of mem_req before the data beat
    logic [31:0] mdata;      // word returned for addr; any other address gets ~mdata
    int          redir_cyc;  // 0: none, else cycle at which l1_addr switches
    logic [31:0] redir_addr;
    int          exp_n;      // strobes expected
    int          exp_cyc;    // cycle of first strobe after request
    int          exp_mem;    // cycles with mem_req high
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, memcyc, run, nstrobe, scyc, stop_at;
    logic [31:0] sdat, waddr;
    waddr   = {v.addr[31:2], 2'b00};
    cyc     = 0;
    memcyc  = 0;
    run     = 0;
    nstrobe = 0;
    scyc    = -1;
    sdat    = '0;
    stop_at = 40;
    l1_req  = 1'b1;
    l1_addr = v.addr;
    while (cyc < stop_at) begin
      @(posedge clk);
      #1;
      cyc++;
      if (v.redir_cyc != 0 && cyc == v.redir_cyc) l1_addr = v.redir_addr;
      if (mem_req) begin
        memcyc++;
        run++;
        if (memcyc == 1) chk("mem_addr", idx, mem_addr, waddr);
      end else begin
        run = 0;
      end
      mem_valid = mem_req && (run == v.lat);
      mem_data  = (mem_addr == waddr) ? v.mdata : ~v.mdata;
      if (l2_valid) begin
        nstrobe++;
        if (scyc < 0) begin
          scyc    = cyc;
          sdat    = l2_data;
          stop_at = cyc + 3;
        end
      end
      if (scyc >= 0 && cyc > scyc) l1_req = 1'b0;
    end
    l1_req    = 1'b0;
    mem_valid = 1'b0;
    chk("strobe_count", idx, 32'(nstrobe), 32'(v.exp_n));
    chk("strobe_cycle", idx, 32'(scyc), 32'(v.exp_cyc));
    chk("strobe_data", idx, sdat, v.exp_data);
    chk("mem_req_cycles", idx, 32'(memcyc), 32'(v.exp_mem));
  endtask

  initial begin
    int   nstrobe;
    vec_t pv;

    //          addr          lat mdata         redir redir_addr   n  cyc mem data
    vecs[0]  = '{32'hBFC00000, 3, 32'h0FF00313, 0, 32'h0,        1, 5,  4, 32'h0FF00313};
    vecs[1]  = '{32'hBFC00000, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'h0FF00313};
    vecs[2]  = '{32'h00000000, 2, 32'h11111111, 0, 32'h0,        1, 4,  3, 32'h11111111};
    vecs[3]  = '{32'h00000800, 1, 32'h22222222, 0, 32'h0,        1, 3,  2, 32'h22222222};
    vecs[4]  = '{32'h00001000, 2, 32'h33333333, 0, 32'h0,        1, 4,  3, 32'h33333333};
    vecs[5]  = '{32'h00000800, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'h22222222};
    vecs[6]  = '{32'h00000000, 1, 32'h44444444, 0, 32'h0,        1, 3,  2, 32'h44444444};
    vecs[7]  = '{32'h00000803, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'h22222222};
    vecs[8]  = '{32'hBFC00000, 1, 32'h55555555, 0, 32'h0,        1, 3,  2, 32'h55555555};
    vecs[9]  = '{32'h7FFFFFFC, 4, 32'hDEADBEEF, 0, 32'h0,        1, 6,  5, 32'hDEADBEEF};
    vecs[10] = '{32'h7FFFFFFC, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'hDEADBEEF};
    vecs[11] = '{32'h00000100, 3, 32'h66666666, 3, 32'h00000200, 1, 11, 8, 32'h99999999};
    vecs[12] = '{32'h00000100, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'h66666666};
    vecs[13] = '{32'h00000200, 1, 32'h0,        0, 32'h0,        1, 2,  0, 32'h99999999};

    rst       = 1'b1;
    l1_req    = 1'b0;
    l1_addr   = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 0, {31'd0, l2_valid}, 32'd0);
    chk("reset_data", 0, l2_data, 32'd0);
    chk("reset_mem_req", 0, {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", 0, mem_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
`ifdef L2_PERF_COUNTERS_EN
      if (i == 1) begin
        chk("miss_count", i, miss_count, 32'd1);
        chk("hit_count", i, hit_count, 32'd1);
      end
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    chk("data_hold", 14, l2_data, vecs[13].exp_data);

    // Reset while waiting on memory, then a stale data beat.
    l1_req  = 1'b1;
    l1_addr = 32'h00000300;
    repeat (3) @(posedge clk);
    #1;
    chk("mem_req_before_rst", 20, {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mem_req", 20, {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", 20, mem_addr, 32'd0);
    chk("rst_data", 20, l2_data, 32'd0);
    chk("rst_valid", 20, {31'd0, l2_valid}, 32'd0);
    l1_req = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_data  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    nstrobe   = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (l2_valid || mem_req) nstrobe++;
    end
    chk("late_mem_valid_ignored", 21, 32'(nstrobe), 32'd0);
    chk("late_mem_data_dropped", 21, l2_data, 32'd0);
`ifdef L2_PERF_COUNTERS_EN
    chk("rst_miss_count", 21, miss_count, 32'd0);
    chk("rst_hit_count", 21, hit_count, 32'd0);
`endif

    pv = '{32'h00000800, 2, 32'h77777777, 0, 32'h0, 1, 4, 3, 32'h77777777};
    run_vec(pv, 22);
    pv = '{32'h00000300, 1, 32'h88888888, 0, 32'h0, 1, 3, 2, 32'h88888888};
    run_vec(pv, 23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
